// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract engine: one shared full-adder cell (two half adders
// plus an OR gate) is stepped LSB first, with operands and results moved
// through valid/ready handshakes on both sides.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  // Single-bit sum and carry
  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

module serial_add_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // The A register doubles as the sum shift register: sum bits enter at the
  // MSB while operand bits leave at the LSB.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept_c;
  logic step_c;
  logic finish_c;

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_sum;
  logic ha1_carry;
  logic carry_next;

  // Shared full-adder cell operating on the current LSBs
  half_adder u_ha0 (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  half_adder u_ha1 (
    .a     (ha0_sum),
    .b     (carry_q),
    .sum   (ha1_sum),
    .carry (ha1_carry)
  );

  assign carry_next = ha0_carry | ha1_carry;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control; abort wins over the final bit
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          step_c = 1'b1;
          if (cnt_q == LAST_BIT) begin
            finish_c = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered handshake/status outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d == BUSY);
      out_valid <= (state_d == DONE);
    end
  end

  // Operand shift registers, carry and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept_c) begin
      a_q     <= in_a;
      b_q     <= in_sub ? ~in_b : in_b;
      carry_q <= in_sub;
      cnt_q   <= '0;
    end else if (step_c) begin
      a_q     <= {ha1_sum, a_q[WIDTH-1:1]};
      b_q     <= b_q >> 1;
      carry_q <= carry_next;
      cnt_q   <= finish_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Result capture on the final bit; held until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result   <= '0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
    end else if (finish_c) begin
      out_result   <= {ha1_sum, a_q[WIDTH-1:1]};
      out_carry    <= carry_next;
      out_overflow <= carry_q ^ carry_next;
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized and directed bench for serial_add_sequencer against a
// transaction-level arithmetic model.

module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sub = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_overflow;

  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;

  // Model state
  logic         m_in_ready = 1'b1;
  logic         m_busy = 1'b0;
  logic         m_out_valid = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_carry = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_res = '0;
  logic         p_carry = 1'b0;
  logic         p_ovf = 1'b0;
  int           m_left = 0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sub       (in_sub),
    .abort        (abort),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: modular result, carry (no-borrow for subtract),
  // signed overflow from the true signed result range
  function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                               output logic [W-1:0] r, output logic c, output logic o);
    longint sa;
    longint sb;
    longint tr;
    longint lim;
    logic [W:0] t;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    tr  = sub ? (sa - sb) : (sa + sb);
    o   = (tr > lim - 1) || (tr < -lim);
    if (sub) begin
      r = a - b;
      c = (a >= b);
    end else begin
      t = {1'b0, a} + {1'b0, b};
      r = t[W-1:0];
      c = t[W];
    end
  endfunction

  // Transaction-level model: accept, count W steps, present result until taken
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_ready  = 1'b1;
      m_busy      = 1'b0;
      m_out_valid = 1'b0;
      m_res       = '0;
      m_carry     = 1'b0;
      m_ovf       = 1'b0;
      m_left      = 0;
    end else if (m_in_ready) begin
      if (in_valid) begin
        calc(in_a, in_b, in_sub, p_res, p_carry, p_ovf);
        m_left     = W;
        m_in_ready = 1'b0;
        m_busy     = 1'b1;
      end
    end else if (m_busy) begin
      if (abort) begin
        m_busy     = 1'b0;
        m_in_ready = 1'b1;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy      = 1'b0;
          m_out_valid = 1'b1;
          m_res       = p_res;
          m_carry     = p_carry;
          m_ovf       = p_ovf;
          n_done++;
        end
      end
    end else if (m_out_valid && out_ready) begin
      m_out_valid = 1'b0;
      m_in_ready  = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("in_ready", 64'(in_ready), 64'(m_in_ready));
    check("busy", 64'(busy), 64'(m_busy));
    check("out_valid", 64'(out_valid), 64'(m_out_valid));
    check("out_result", 64'(out_result), 64'(m_res));
    check("out_carry", 64'(out_carry), 64'(m_carry));
    check("out_overflow", 64'(out_overflow), 64'(m_ovf));
  end

  // Directed operation with literal expectations, latency and hold checks
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] er, input logic ec, input logic eo, input int hold);
    int n;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
    check("model_res", 64'(p_res), 64'(er));
    check("model_carry", 64'(p_carry), 64'(ec));
    check("model_ovf", 64'(p_ovf), 64'(eo));
    n = 0;
    while (!out_valid && n < 4 * W) begin
      @(posedge clk); #2;
      n++;
    end
    check("latency", 64'(n), 64'(W));
    check("op_result", 64'(out_result), 64'(er));
    check("op_carry", 64'(out_carry), 64'(ec));
    check("op_overflow", 64'(out_overflow), 64'(eo));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_result", 64'(out_result), 64'(er));
      check("hold_carry", 64'(out_carry), 64'(ec));
      check("hold_overflow", 64'(out_overflow), 64'(eo));
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    check("release_in_ready", 64'(in_ready), 64'(1));
    check("release_valid", 64'(out_valid), 64'(0));
    check("release_result", 64'(out_result), 64'(er));
  endtask

  // Abort 0x0F+0x01 on the edge that processes bit idx
  task automatic abort_at(input int idx, input logic [W-1:0] prev);
    in_a = W'(8'h0F); in_b = W'(8'h01); in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    for (int i = 0; i < idx; i++) begin
      @(posedge clk); #2;
    end
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #2;
      check("abort_no_valid", 64'(out_valid), 64'(0));
      check("abort_result_kept", 64'(out_result), 64'(prev));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(out_result), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #2;

    do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    do_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 5);
    do_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 0);

    abort_at(3, 8'h96);
    abort_at(W - 1, 8'h96);

    // Asynchronous reset in the middle of an operation
    in_a = 8'h0F; in_b = 8'h01; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'(1));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_result", 64'(out_result), 64'(0));
    check("arst_carry", 64'(out_carry), 64'(0));
    check("arst_overflow", 64'(out_overflow), 64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0);

    // Random traffic with backpressure, idle gaps and aborts
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_sub    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #2;
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (2 * W + 4) @(posedge clk);
    #2;
    check("random_completions", 64'(n_done > 20), 64'(1));
    check("drain_in_ready", 64'(in_ready), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
